seg7_axis_decoder: RTL and testbench

//  AXI-Stream sink for two-digit 7-segment words from the accumulator output stage.

---
 rtl/seg7_axis_decoder.sv | 118 +++++++++++
 tb/tb_seg7_axis_decoder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_axis_decoder.sv
// Two-digit 7-segment AXI-Stream sink: decodes to BCD and binary, flags illegal codes, buffers in a FIFO.
// Optional macro SEG7_DROP_ILLEGAL_EN: illegal beats are consumed but never forwarded.
module seg7_axis_decoder #(
    parameter int W_OUT = 7,
    parameter int DEPTH = 2,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [1:0][6:0]  s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W_OUT-1:0] m_data,
    output logic [7:0]       m_bcd,
    output logic             m_err,
    input  logic             err_clr,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 16;  // {err, bcd[7:0], value[6:0]}

    // Returns {legal, digit}; blank_ok makes the all-off pattern a legal zero.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg, input logic blank_ok);
        logic [4:0] r;
        case (seg)
            7'b0111111: r = 5'b1_0000;
            7'b0000110: r = 5'b1_0001;
            7'b1011011: r = 5'b1_0010;
            7'b1001111: r = 5'b1_0011;
            7'b1100110: r = 5'b1_0100;
            7'b1101101: r = 5'b1_0101;
            7'b1111101: r = 5'b1_0110;
            7'b0000111: r = 5'b1_0111;
            7'b1111111: r = 5'b1_1000;
            7'b1101111: r = 5'b1_1001;
            7'b0000000: r = blank_ok ? 5'b1_0000 : 5'b0_0000;
            default:    r = 5'b0_0000;
        endcase
        return r;
    endfunction

    logic [4:0]    tens_dec, ones_dec;
    logic          legal;
    logic [6:0]    bin_val;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] rd_entry;

    always_comb begin
        tens_dec = seg_decode(s_data[1], 1'b1);
        ones_dec = seg_decode(s_data[0], 1'b0);
        legal    = tens_dec[4] && ones_dec[4];
        bin_val  = {3'b000, tens_dec[3:0]} * 7'd10 + {3'b000, ones_dec[3:0]};
`ifdef SEG7_DROP_ILLEGAL_EN
        wr_entry = {1'b0, tens_dec[3:0], ones_dec[3:0], bin_val};
`else
        wr_entry = {!legal, tens_dec[3:0], ones_dec[3:0], bin_val};
`endif
    end

    logic [AW:0]   wr_ptr, rd_ptr;
    logic [EW-1:0] mem [DEPTH];
    logic          ready_en;
    logic          full, empty;
    logic          accept, push, pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    // ready_en holds s_ready low through reset and the first edge after release.
    assign s_ready = ready_en && !full;
    assign m_valid = !empty;
    assign accept  = s_valid && s_ready;
    assign pop     = m_valid && m_ready;
`ifdef SEG7_DROP_ILLEGAL_EN
    assign push    = accept && legal;
`else
    assign push    = accept;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ready_en <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= wr_entry;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign rd_entry = mem[rd_ptr[AW-1:0]];
    assign m_data   = W_OUT'(rd_entry[6:0]);
    assign m_bcd    = rd_entry[14:7];
`ifdef SEG7_DROP_ILLEGAL_EN
    assign m_err    = 1'b0;
`else
    assign m_err    = rd_entry[15];
`endif

    // Clear wins over an increment landing on the same edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (accept && !legal && (err_cnt != {ERR_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_seg7_axis_decoder.sv
// Scoreboard bench for seg7_axis_decoder: directed beats, expected queue, monitor on m_* handshakes.
// Handshake: a beat transfers on a rising edge where valid && ready; sources hold data while valid && !ready.
module tb_seg7_axis_decoder;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [1:0][6:0] s_data = '0;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [6:0]      m_data;
    logic [7:0]      m_bcd;
    logic            m_err;
    logic            err_clr = 1'b0;
    logic [7:0]      err_cnt;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    localparam logic [6:0] S0 = 7'b0111111, S1 = 7'b0000110, S2 = 7'b1011011,
                           S3 = 7'b1001111, S4 = 7'b1100110, S5 = 7'b1101101,
                           S7 = 7'b0000111, S8 = 7'b1111111, BL = 7'b0000000,
                           BAD = 7'b1010101;

    seg7_axis_decoder #(.W_OUT(7), .DEPTH(2), .ERR_W(8)) dut (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_bcd(m_bcd),
        .m_err(m_err), .err_clr(err_clr), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pack(input logic err, input logic [7:0] bcd, input logic [6:0] val);
        return {err, bcd, val};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic monitor_loop();
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (rstn && m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(pack(m_err, m_bcd, m_data)), 32'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 32'(pack(m_err, m_bcd, m_data)), 32'(e));
                end
            end
        end
    endtask

    // Drives one beat, waits (bounded) for s_ready, returns #1 after the accepting edge.
    task automatic send(input logic [6:0] t, input logic [6:0] o, input logic [15:0] e, input logic legal);
        int n;
        s_data  = {t, o};
        s_valid = 1'b1;
        n = 0;
        while (!s_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!s_ready) begin
            check("send_timeout", 32'(s_ready), 32'd1);
        end else begin
            @(posedge clk);
`ifdef SEG7_DROP_ILLEGAL_EN
            if (legal) exp_q.push_back(e);
`else
            exp_q.push_back(e);
`endif
        end
        #1;
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        fork
            monitor_loop();
        join_none

        // Reset state
        #1;
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_err", 32'(m_err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        #22;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_s_ready", 32'(s_ready), 32'd1);

        // 1: single beat 58 with one-cycle latency
        m_ready = 1'b1;
        send(S5, S8, pack(1'b0, 8'h58, 7'd58), 1'b1);
        check("t1_latency_valid", 32'(m_valid), 32'd1);
        check("t1_data", 32'(m_data), 32'd58);
        drain();

        // 2: backpressure with DEPTH=2
        m_ready = 1'b0;
        send(BL, S1, pack(1'b0, 8'h01, 7'd1), 1'b1);
        send(S1, S2, pack(1'b0, 8'h12, 7'd12), 1'b1);
        check("t2_full_s_ready", 32'(s_ready), 32'd0);
        fork
            send(S4, S7, pack(1'b0, 8'h47, 7'd47), 1'b1);
            begin
                @(posedge clk);
                #1;
                check("t2_stall_data_a", 32'(m_data), 32'd1);
                @(posedge clk);
                #1;
                check("t2_stall_data_b", 32'(m_data), 32'd1);
                check("t2_still_full", 32'(s_ready), 32'd0);
                m_ready = 1'b1;
            end
        join
        drain();

        // 3: blanked tens legal, blank ones illegal
        send(BL, S3, pack(1'b0, 8'h03, 7'd3), 1'b1);
        check("t3_err_cnt_0", 32'(err_cnt), 32'd0);
        send(S1, BL, pack(1'b1, 8'h10, 7'd10), 1'b0);
        check("t3_err_cnt_1", 32'(err_cnt), 32'd1);
        drain();

        // 4: saturation and clear priority
        for (int i = 0; i < 300; i++) send(BL, BAD, pack(1'b1, 8'h00, 7'd0), 1'b0);
        check("t4_err_sat", 32'(err_cnt), 32'd255);
        err_clr = 1'b1;
        send(BL, BAD, pack(1'b1, 8'h00, 7'd0), 1'b0);
        err_clr = 1'b0;
        check("t4_err_clr", 32'(err_cnt), 32'd0);
        drain();

        // 5: asynchronous reset with buffered beats
        m_ready = 1'b0;
        send(S2, S0, pack(1'b0, 8'h20, 7'd20), 1'b1);
        send(S7, S3, pack(1'b0, 8'h73, 7'd73), 1'b1);
        check("t5_m_valid_pre", 32'(m_valid), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        exp_q.delete();
        check("t5_m_valid_rst", 32'(m_valid), 32'd0);
        check("t5_m_data_rst", 32'(m_data), 32'd0);
        check("t5_s_ready_rst", 32'(s_ready), 32'd0);
        #10;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("t5_s_ready_post", 32'(s_ready), 32'd1);
        check("t5_empty_post", 32'(m_valid), 32'd0);

        // 6: legal, illegal, legal (illegal dropped when the drop build is used)
        m_ready = 1'b1;
        send(S8, S1, pack(1'b0, 8'h81, 7'd81), 1'b1);
        send(BAD, S4, pack(1'b1, 8'h04, 7'd4), 1'b0);
        send(S3, S3, pack(1'b0, 8'h33, 7'd33), 1'b1);
        check("t6_err_cnt", 32'(err_cnt), 32'd1);
        drain();
        check("final_m_valid", 32'(m_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
